peak_search: RTL

Correlation peak detector that consumes the truncated correlation stream produced by the zero-drop output stage after the IFFT. Over one frame of N1+N2-1 complex samples it computes |x|² per sample and tracks the maximum and its index. At frame end it reports the peak value, the peak index and a threshold-detect flag with a one-cycle `done` pulse. It is the final stage of the fast correlation chain and sits in front of the control/readout logic.

---
 rtl/corr_pkg.sv | 17 +
 rtl/cplx_mag_sq.sv | 44 ++++
 rtl/peak_search.sv | 125 ++++++++++++
 3 files changed

// File: rtl/corr_pkg.sv
// Shared types and constants for the back end of the fast correlation chain.
package corr_pkg;

    localparam int IDX_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        REPORT
    } peak_state_t;

    function automatic int CPLX_HALF(input int data_w);
        return data_w / 2;
    endfunction

endpackage

// File: rtl/cplx_mag_sq.sv
// One-stage registered |x|^2 of a packed {im, re} sample, with valid and index carried alongside.
module cplx_mag_sq
    import corr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic [IDX_W-1:0]  sample_index,
    output logic              mag_valid,
    output logic [IDX_W-1:0]  mag_index,
    output logic [DATA_W-1:0] mag
);

    localparam int HALF = CPLX_HALF(DATA_W);

    logic signed [DATA_W-1:0] re_ext;
    logic signed [DATA_W-1:0] im_ext;
    logic        [DATA_W-1:0] re_sq;
    logic        [DATA_W-1:0] im_sq;

    assign re_ext = {{HALF{sample[HALF-1]}}, sample[HALF-1:0]};
    assign im_ext = {{HALF{sample[DATA_W-1]}}, sample[DATA_W-1:HALF]};

    // Each square is at most 2^(DATA_W-2), so the sum of two never wraps.
    always_ff @(posedge aclk) begin
        if (areset) begin
            re_sq     <= '0;
            im_sq     <= '0;
            mag_index <= '0;
            mag_valid <= 1'b0;
        end else begin
            re_sq     <= re_ext * re_ext;
            im_sq     <= im_ext * im_ext;
            mag_index <= sample_index;
            mag_valid <= sample_valid;
        end
    end

    assign mag = re_sq + im_sq;

endmodule

// File: rtl/peak_search.sv
// Frame-based |x|^2 peak tracker: reports max value, its index and a threshold flag at frame end.
module peak_search
    import corr_pkg::*;
#(
    parameter int NFFT   = 256,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [12:0]       N1,
    input  logic [12:0]       N2,
    input  logic [DATA_W-1:0] threshold,
    input  logic              start,
    input  logic [DATA_W-1:0] indata_tdata,
    input  logic              indata_tvalid,
    output logic              indata_tready,
    output logic [DATA_W-1:0] peak_value,
    output logic [IDX_W-1:0]  peak_index,
    output logic              detect,
    output logic              done
);

    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(NFFT);

    peak_state_t       state;
    logic [IDX_W-1:0]  count;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  frame_len;
    logic [DATA_W-1:0] thresh;
    logic [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]  max_idx;
    logic [DATA_W-1:0] mag;
    logic [IDX_W-1:0]  mag_index;
    logic              mag_valid;
    logic              flush_second;
    logic              handshake;

    assign handshake = indata_tvalid && indata_tready;

    // Frame length clamps to the FFT size so the index counter can never run past a real frame.
    always_comb begin
        frame_len = {1'b0, N1} + {1'b0, N2} - IDX_W'(1);
        if (frame_len > MAX_LEN) begin
            frame_len = MAX_LEN;
        end
    end

    cplx_mag_sq #(
        .DATA_W(DATA_W)
    ) u_mag (
        .aclk         (aclk),
        .areset       (areset),
        .sample       (indata_tdata),
        .sample_valid (handshake),
        .sample_index (count),
        .mag_valid    (mag_valid),
        .mag_index    (mag_index),
        .mag          (mag)
    );

    // Strict greater-than keeps the earliest index on ties; two flush cycles let the last
    // accepted sample clear both pipeline stages before the result is published.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= IDLE;
            indata_tready <= 1'b0;
            done          <= 1'b0;
            detect        <= 1'b0;
            peak_value    <= '0;
            peak_index    <= '0;
            count         <= '0;
            last_idx      <= '0;
            thresh        <= '0;
            max_val       <= '0;
            max_idx       <= '0;
            flush_second  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mag_valid && (mag > max_val)) begin
                max_val <= mag;
                max_idx <= mag_index;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        last_idx      <= frame_len - IDX_W'(1);
                        thresh        <= threshold;
                        max_val       <= '0;
                        max_idx       <= '0;
                        count         <= '0;
                        indata_tready <= 1'b1;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (handshake) begin
                        count <= count + IDX_W'(1);
                        if (count == last_idx) begin
                            indata_tready <= 1'b0;
                            flush_second  <= 1'b0;
                            state         <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    flush_second <= 1'b1;
                    if (flush_second) begin
                        peak_value <= max_val;
                        peak_index <= max_idx;
                        detect     <= (max_val > thresh);
                        done       <= 1'b1;
                        state      <= REPORT;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
